// File: rtl/note_sequencer_if.sv
// Host-side bundle for note_sequencer.
// Covers control, pattern write port and channel outputs.
interface note_sequencer_if #(
  parameter int ADDR_W  = 4,
  parameter int TEMPO_W = 16
);
  logic               start;
  logic               stop;
  logic               loop_en;
  logic [TEMPO_W-1:0] tempo;
  logic [ADDR_W-1:0]  length;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [7:0]         wr_freq1;
  logic [7:0]         wr_freq2;
  logic [1:0]         wr_gate;
  logic [7:0]         freq1;
  logic [7:0]         freq2;
  logic [1:0]         gate;
  logic [ADDR_W-1:0]  step_idx;
  logic               busy;
  logic               step_tick;
  logic               done;

  modport master (
    output start, stop, loop_en, tempo, length,
    output wr_en, wr_addr, wr_freq1, wr_freq2, wr_gate,
    input  freq1, freq2, gate, step_idx,
    input  busy, step_tick, done
  );

  modport slave (
    input  start, stop, loop_en, tempo, length,
    input  wr_en, wr_addr, wr_freq1, wr_freq2, wr_gate,
    output freq1, freq2, gate, step_idx,
    output busy, step_tick, done
  );
endinterface

// File: rtl/note_sequencer.sv
// Two-channel step sequencer driving freq1/freq2/gate
// from a small programmable pattern memory.
module note_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int TEMPO_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  note_sequencer_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PLAY = 1'b1;

  typedef struct packed {
    logic [1:0] gate;
    logic [7:0] f2;
    logic [7:0] f1;
  } step_t;

  step_t              mem [DEPTH];
  logic [0:0]         state_q;
  logic [TEMPO_W-1:0] tempo_q;
  logic [TEMPO_W-1:0] cnt_q;
  logic [ADDR_W-1:0]  len_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [ADDR_W-1:0]  nxt_idx;
  step_t              out_q;
  logic               busy_q;
  logic               tick_q;
  logic               done_q;

  assign nxt_idx = idx_q + 1'b1;

  // Memory reads are taken before this edge's write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tempo_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (bus.wr_en) begin
        mem[bus.wr_addr] <= {bus.wr_gate, bus.wr_freq2, bus.wr_freq1};
      end
      tick_q <= 1'b0;
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.start && !bus.stop) begin
          tempo_q <= bus.tempo;
          len_q   <= bus.length;
          cnt_q   <= bus.tempo;
          idx_q   <= '0;
          out_q   <= mem[0];
          busy_q  <= 1'b1;
          tick_q  <= 1'b1;
          state_q <= PLAY;
        end
      end else if (bus.stop) begin
        state_q <= IDLE;
        idx_q   <= '0;
        out_q   <= '0;
        busy_q  <= 1'b0;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end else if (idx_q != len_q) begin
        idx_q  <= nxt_idx;
        out_q  <= mem[nxt_idx];
        cnt_q  <= tempo_q;
        tick_q <= 1'b1;
      end else if (bus.loop_en) begin
        idx_q  <= '0;
        out_q  <= mem[0];
        cnt_q  <= tempo_q;
        tick_q <= 1'b1;
      end else begin
        state_q <= IDLE;
        idx_q   <= '0;
        out_q   <= '0;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end
  end

  assign bus.freq1     = out_q.f1;
  assign bus.freq2     = out_q.f2;
  assign bus.gate      = out_q.gate;
  assign bus.step_idx  = idx_q;
  assign bus.busy      = busy_q;
  assign bus.step_tick = tick_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer.
// Expected output vectors are queued per cycle and popped on negedge.
module tb_note_sequencer;
  logic clk;
  logic rst_n;

  note_sequencer_if #(.ADDR_W(4), .TEMPO_W(16)) bus ();

  note_sequencer #(.ADDR_W(4), .TEMPO_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int t;
    int len;
    int done_cyc;
  } scen_t;

  logic [24:0] q [$];
  string       tq [$];
  logic [7:0]  mf1 [16];
  logic [7:0]  mf2 [16];
  logic [1:0]  mg  [16];
  int          n_chk;
  int          n_pass;
  logic [24:0] act;
  logic [24:0] e;
  string       en;

  assign act = {bus.freq1, bus.freq2, bus.gate, bus.step_idx,
                bus.busy, bus.step_tick, bus.done};

  function automatic logic [24:0] mk(
    input logic [7:0] f1, input logic [7:0] f2,
    input logic [1:0] g, input logic [3:0] idx,
    input logic b, input logic t, input logic d);
    return {f1, f2, g, idx, b, t, d};
  endfunction

  task automatic chk(input string nm, input logic [24:0] a,
                     input logic [24:0] x);
    n_chk++;
    if (a === x) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, a, x);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      e  = q.pop_front();
      en = tq.pop_front();
      chk(en, act, e);
    end
  end

  task automatic push(input logic [24:0] v, input string nm);
    q.push_back(v);
    tq.push_back(nm);
  endtask

  task automatic push_zero(input string nm, input logic d);
    push(mk(8'h0, 8'h0, 2'b0, 4'h0, 1'b0, 1'b0, d), nm);
  endtask

  // Closed form: cycle c plays step (c / (t+1)) mod (len+1).
  task automatic exp_play(input int t, input int len, input int n,
                          input string nm);
    for (int c = 0; c < n; c++) begin
      int k;
      logic [3:0] ki;
      k  = (c / (t + 1)) % (len + 1);
      ki = k[3:0];
      push(mk(mf1[k], mf2[k], mg[k], ki, 1'b1,
              (c % (t + 1)) == 0, 1'b0),
           $sformatf("%s_c%0d", nm, c));
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    #1;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else begin
      $display("FAIL %s_timeout: left %0d want 0", nm, q.size());
      q.delete();
      tq.delete();
    end
  endtask

  task automatic wr(input int a, input logic [7:0] f1,
                    input logic [7:0] f2, input logic [1:0] g);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = a[3:0];
    bus.wr_freq1 = f1;
    bus.wr_freq2 = f2;
    bus.wr_gate  = g;
    @(negedge clk); #1;
    bus.wr_en = 1'b0;
    mf1[a] = f1;
    mf2[a] = f2;
    mg[a]  = g;
  endtask

  task automatic go();
    bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  initial begin
    scen_t tbl [4];
    tbl[0] = '{3, 2, 12};
    tbl[1] = '{0, 2, 3};
    tbl[2] = '{1, 0, 2};
    tbl[3] = '{2, 3, 12};

    n_chk  = 0;
    n_pass = 0;
    for (int i = 0; i < 16; i++) begin
      mf1[i] = '0;
      mf2[i] = '0;
      mg[i]  = '0;
    end
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.loop_en  = 1'b0;
    bus.tempo    = '0;
    bus.length   = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_freq1 = '0;
    bus.wr_freq2 = '0;
    bus.wr_gate  = '0;
    #12;
    rst_n = 1'b1;
    chk("reset", act, '0);

    wr(0, 8'h20, 8'h10, 2'b01);
    wr(1, 8'h40, 8'h30, 2'b11);
    wr(2, 8'h60, 8'h50, 2'b10);
    wr(3, 8'h80, 8'h70, 2'b11);

    push_zero("idle_ss0", 1'b0);
    push_zero("idle_ss1", 1'b0);
    bus.tempo  = 16'd3;
    bus.length = 4'd2;
    bus.start  = 1'b1;
    bus.stop   = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    drain("idle_ss");

    foreach (tbl[i]) begin
      bus.tempo   = tbl[i].t[15:0];
      bus.length  = tbl[i].len[3:0];
      bus.loop_en = 1'b0;
      exp_play(tbl[i].t, tbl[i].len, tbl[i].done_cyc,
               $sformatf("tbl%0d", i));
      push_zero($sformatf("tbl%0d_done", i), 1'b1);
      push_zero($sformatf("tbl%0d_idle", i), 1'b0);
      go();
      drain($sformatf("tbl%0d", i));
    end

    bus.tempo   = 16'd3;
    bus.length  = 4'd2;
    bus.loop_en = 1'b1;
    exp_play(3, 2, 24, "loop");
    push_zero("loop_done", 1'b1);
    push_zero("loop_idle", 1'b0);
    go();
    cyc(14);
    bus.loop_en = 1'b0;
    drain("loop");

    exp_play(3, 2, 6, "stop");
    push_zero("stop_z0", 1'b0);
    push_zero("stop_z1", 1'b0);
    go();
    cyc(5);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    drain("stop");

    exp_play(3, 2, 12, "stop_end");
    push_zero("stop_end_z0", 1'b0);
    push_zero("stop_end_z1", 1'b0);
    go();
    cyc(11);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    drain("stop_end");

    bus.tempo   = 16'd0;
    bus.length  = 4'd0;
    bus.loop_en = 1'b1;
    exp_play(0, 0, 7, "one");
    for (int i = 0; i < 3; i++) begin
      push(mk(8'hBB, 8'hAA, 2'b11, 4'h0, 1'b1, 1'b1, 1'b0),
           $sformatf("one_new%0d", i));
    end
    push_zero("one_z0", 1'b0);
    push_zero("one_z1", 1'b0);
    go();
    cyc(5);
    bus.wr_addr  = 4'd0;
    bus.wr_freq1 = 8'hBB;
    bus.wr_freq2 = 8'hAA;
    bus.wr_gate  = 2'b11;
    bus.wr_en    = 1'b1;
    cyc(1);
    bus.wr_en = 1'b0;
    mf1[0] = 8'hBB;
    mf2[0] = 8'hAA;
    mg[0]  = 2'b11;
    cyc(3);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop    = 1'b0;
    bus.loop_en = 1'b0;
    drain("one");

    bus.tempo  = 16'd3;
    bus.length = 4'd2;
    exp_play(3, 2, 12, "ign");
    push_zero("ign_done", 1'b1);
    push_zero("ign_idle", 1'b0);
    go();
    cyc(2);
    bus.start = 1'b1;
    bus.tempo = 16'd0;
    cyc(4);
    bus.start = 1'b0;
    drain("ign");
    bus.tempo = 16'd3;

    exp_play(3, 2, 3, "arst");
    go();
    cyc(2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_now", act, '0);
    #1;
    rst_n = 1'b1;
    cyc(1);
    for (int i = 0; i < 16; i++) begin
      mf1[i] = '0;
      mf2[i] = '0;
      mg[i]  = '0;
    end
    bus.tempo  = 16'd1;
    bus.length = 4'd1;
    exp_play(1, 1, 4, "cleared");
    push_zero("cleared_done", 1'b1);
    push_zero("cleared_idle", 1'b0);
    go();
    drain("cleared");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Two-channel step sequencer that drives the `freq1`/`freq2` frequency-control inputs of the square and sawtooth channels from a small programmable pattern memory, replacing the static switch controls when a pattern is playing. Each step holds one frequency control word per channel plus a per-channel gate. The tempo counter advances the pattern; start/stop/loop control comes from the host side. `gate` is used downstream to mute a channel before the mixer.

## Interface

Parameters:
- `ADDR_W`, 4, pattern address width; the memory holds 2^ADDR_W steps.
- `TEMPO_W`, 16, width of the step-duration field.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  level; starts playback when sampled in IDLE.
- `stop`  in  1  level; aborts playback.
- `loop_en`  in  1  sampled live at end of pattern; 1 = wrap to step 0.
- `tempo`  in  TEMPO_W  step duration minus 1, in clk cycles; latched at start.
- `length`  in  ADDR_W  index of the last step; latched at start.
- `wr_en`  in  1  pattern memory write strobe.
- `wr_addr`  in  ADDR_W  write address.
- `wr_freq1`  in  8  channel 1 frequency control word.
- `wr_freq2`  in  8  channel 2 frequency control word.
- `wr_gate`  in  2  gate bits; [0] = channel 1, [1] = channel 2.
- `freq1`  out  8  registered frequency control for channel 1.
- `freq2`  out  8  registered frequency control for channel 2.
- `gate`  out  2  registered channel gates.
- `step_idx`  out  ADDR_W  index of the step currently output.
- `busy`  out  1  1 while in PLAY.
- `step_tick`  out  1  one-cycle pulse in the first cycle of every step.
- `done`  out  1  one-cycle pulse on natural pattern end (not on stop).

## Operation

**Memory**
- 2^ADDR_W entries of {gate[1:0], freq2[7:0], freq1[7:0]}.
- Synchronous write, accepted in any state.
- Read is combinational. A step load at the same edge as a write to that address gets the old contents.
- Reset clears every entry to 0.

**State machine: IDLE, PLAY**
- IDLE
  - `freq1`, `freq2`, `gate`, `step_idx`, `busy`, `done`, `step_tick` are all 0.
  - `start`=1 and `stop`=0 at an edge:
    - latch `tempo` into `tempo_q` and `length` into `len_q`;
    - load entry 0 into the outputs;
    - set `step_idx`=0, counter = `tempo_q`, `busy`=1, `step_tick`=1;
    - go to PLAY.
- PLAY, evaluated in priority order:
  1. `stop`=1: go to IDLE. All outputs clear at that edge. No `done`.
  2. Counter ≠ 0: decrement the counter.
  3. Counter = 0 and `step_idx` ≠ `len_q`: `step_idx`+1, load that entry, reload counter from `tempo_q`, pulse `step_tick`.
  4. Counter = 0, `step_idx` = `len_q`, `loop_en`=1: `step_idx`=0, load entry 0, reload counter, pulse `step_tick`.
  5. Counter = 0, `step_idx` = `len_q`, `loop_en`=0: go to IDLE, clear outputs, pulse `done` for one cycle.
- `start` in PLAY is ignored.
- `tempo`/`length` changes during PLAY have no effect until the next start.
- Memory writes during PLAY take effect the next time the affected step is loaded.
- `len_q`=0 is a single-step pattern. With `loop_en`=1 it re-loads step 0 every tempo+1 cycles and pulses `step_tick` each time.

**Reset**
- `rst_n` low at any time, including mid-step: immediately enter IDLE, clear all outputs, counter, latches and memory.
- After release, the first start is accepted at the first rising edge with `rst_n` high.

## Timing

- All outputs are registered. No combinational path from any input to any output.
- Start latency: `start` sampled at edge E makes step 0 visible after E, with `step_tick`=1 in that cycle.
- Each step is held for exactly `tempo_q`+1 cycles. `tempo`=0 gives one cycle per step.
- Non-looping pattern: `done` is high in cycle (len_q+1)·(tempo_q+1) after E, with `busy`=0 in that same cycle.
- A new start is accepted in the cycle `done` is high, since the FSM is already in IDLE.
- Stop latency: `stop` sampled at edge S gives `busy`=0 and zero outputs after S.
- `stop` and counter expiry at the same edge: stop wins, no `done`.
- `start` and `stop` together in IDLE: stay IDLE.

## Test plan

1. Reset values: after reset, write entries 0–2 = {2'b01, 8'h10, 8'h20}, {2'b11, 8'h30, 8'h40}, {2'b10, 8'h50, 8'h60}.
   - Stimulus: `tempo`=3, `length`=2, `loop_en`=0, pulse `start`.
   - Required response: each step is held 4 cycles; `step_tick` fires at cycles 0, 4 and 8; `done` fires at cycle 12 with all outputs 0.
2. Loop wrap:
   - Stimulus: same pattern with `loop_en`=1.
   - Required response: after step 2, step 0 reappears at cycle 12 (`freq1`=8'h20); no `done`. Drop `loop_en` during the second pass: `done` fires at cycle 24.
3. Stop mid-step:
   - Stimulus: assert `stop` at cycle 5 of test 1.
   - Required response: the next cycle has `busy`=0, `freq1`=`freq2`=0, `gate`=0, and no `done`. Assert `stop` together with the final counter expiry: no `done`.
4. `tempo`=0, `length`=0, `loop_en`=1:
   - Required response: `step_tick` is high every cycle and `step_idx` stays 0.
   - Then write entry 0 = {2'b11, 8'hAA, 8'hBB} during play: the new value appears on the outputs from the following step load.
5. Asynchronous reset:
   - Stimulus: assert `rst_n`=0 mid-step while playing.
   - Required response: outputs are 0 with no clock edge. After release, `start` plays all-zero entries, confirming the memory was cleared.
6. Ignored start:
   - Stimulus: re-assert `start` during PLAY, and change `tempo` to 0 mid-pattern.
   - Required response: step timing is unchanged (4-cycle steps), with no restart.
